// File: rtl/tft_pkg.sv
// Shared definitions for the TFT cell painter: object codes, RGB565 colours,
// 8080 command opcodes, default grid geometry and the controller state set.
package tft_pkg;

   localparam int CELL_PX_DEF = 20;
   localparam int GRID_W_DEF  = 16;
   localparam int GRID_H_DEF  = 12;

   localparam logic [7:0] OP_CASET = 8'h2A;
   localparam logic [7:0] OP_PASET = 8'h2B;
   localparam logic [7:0] OP_RAMWR = 8'h2C;

   typedef enum logic [2:0] {
      OBJ_EMPTY  = 3'b000,
      OBJ_HEAD   = 3'b001,
      OBJ_BODY   = 3'b010,
      OBJ_APPLE  = 3'b011,
      OBJ_BORDER = 3'b100
   } obj_e;

   localparam logic [15:0] COLOR_EMPTY   = 16'h0000;
   localparam logic [15:0] COLOR_HEAD    = 16'hFFE0;
   localparam logic [15:0] COLOR_BODY    = 16'h07E0;
   localparam logic [15:0] COLOR_APPLE   = 16'hF800;
   localparam logic [15:0] COLOR_BORDER  = 16'hFFFF;
   localparam logic [15:0] COLOR_INVALID = 16'hF81F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CASET_CMD,
      ST_CASET_PAR,
      ST_PASET_CMD,
      ST_PASET_PAR,
      ST_RAMWR_CMD,
      ST_PIXELS,
      ST_DONE
   } state_e;

   // Unused codes paint magenta so they stand out on the panel.
   function automatic logic [15:0] obj_color(input logic [2:0] code);
      logic [15:0] c;
      case (code)
         OBJ_EMPTY:  c = COLOR_EMPTY;
         OBJ_HEAD:   c = COLOR_HEAD;
         OBJ_BODY:   c = COLOR_BODY;
         OBJ_APPLE:  c = COLOR_APPLE;
         OBJ_BORDER: c = COLOR_BORDER;
         default:    c = COLOR_INVALID;
      endcase
      return c;
   endfunction

   // Window parameter bytes in bus order: start hi, start lo, end hi, end lo.
   function automatic logic [7:0] coord_byte(input logic [1:0] idx,
                                             input logic [15:0] c0,
                                             input logic [15:0] c1);
      logic [7:0] b;
      case (idx)
         2'd0:    b = c0[15:8];
         2'd1:    b = c0[7:0];
         2'd2:    b = c1[15:8];
         default: b = c1[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/tft_byte_writer.sv
// Two-phase 8080 byte strobe: phase A drives wrx low with data/dcx valid,
// phase B raises wrx (the panel latches on that edge) with data held.
// A new byte may be loaded during phase B, giving one byte every two cycles.
module tft_byte_writer (
   input  logic       clk,
   input  logic       nrst,
   input  logic       load_i,
   input  logic [7:0] data_i,
   input  logic       dcx_i,
   output logic       ready_o,
   output logic       wrx_o,
   output logic       dcx_o,
   output logic [7:0] data_o
);

   logic       wrx_q, wrx_d;
   logic       dcx_q, dcx_d;
   logic [7:0] data_q, data_d;

   // Ready whenever wrx is high: idle, or in phase B of the previous byte.
   assign ready_o = wrx_q;
   assign wrx_o   = wrx_q;
   assign dcx_o   = dcx_q;
   assign data_o  = data_q;

   // Next-state: start phase A on an accepted load, otherwise finish with phase B.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      wrx_d  = 1'b1;
      dcx_d  = dcx_q;
      data_d = data_q;
      if (load_i && wrx_q) begin
         wrx_d  = 1'b0;
         dcx_d  = dcx_i;
         data_d = data_i;
      end
   end

   // Strobe/data registers, bus parked at idle levels in reset.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
         wrx_q  <= 1'b1;
         dcx_q  <= 1'b1;
         data_q <= 8'h00;
      end else begin
         wrx_q  <= wrx_d;
         dcx_q  <= dcx_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/cell_painter.sv
// Paints one grid cell on an 8080-bus TFT: sets the column and page window
// to the cell, issues RAMWR and streams CELL_PX*CELL_PX RGB565 pixels.
module cell_painter
   import tft_pkg::*;
#(
   parameter int CELL_PX = CELL_PX_DEF,
   parameter int GRID_W  = GRID_W_DEF,
   parameter int GRID_H  = GRID_H_DEF
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       en_update,
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [2:0] obj_code,
   output logic       cmd_done,
   output logic       busy,
   output logic       tft_csx,
   output logic       tft_dcx,
   output logic       tft_wrx,
   output logic [7:0] tft_data
);

   localparam int PIX_N = CELL_PX * CELL_PX;
   localparam int PIX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_N - 1);

   state_e           state_q, state_d;
   logic [3:0]       x_q, x_d, y_q, y_d;
   logic [2:0]       obj_q, obj_d;
   logic [1:0]       idx_q, idx_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic             lo_q, lo_d;
   logic             csx_q, busy_q, done_q;

   logic             wr_load, wr_dcx, wr_ready;
   logic [7:0]       wr_data;
   logic [15:0]      x0, x1, y0, y1, color;
   logic             in_range;

   assign in_range = (32'(x) < GRID_W) && (32'(y) < GRID_H);
   assign x0       = 16'(32'(x_q) * CELL_PX);
   assign x1       = x0 + 16'(CELL_PX - 1);
   assign y0       = 16'(32'(y_q) * CELL_PX);
   assign y1       = y0 + 16'(CELL_PX - 1);
   assign color    = obj_color(obj_q);

   // Sequencer: each state loads the next byte while the previous one is in phase B.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      obj_d   = obj_q;
      idx_d   = idx_q;
      pix_d   = pix_q;
      lo_d    = lo_q;
      wr_load = 1'b0;
      wr_data = 8'h00;
      wr_dcx  = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (en_update) begin
               x_d   = x;
               y_d   = y;
               obj_d = obj_code;
               if (in_range) begin
                  wr_load = 1'b1;
                  wr_data = OP_CASET;
                  wr_dcx  = 1'b0;
                  state_d = ST_CASET_CMD;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_CASET_CMD: begin
            if (wr_ready) begin
               wr_load = 1'b1;
               wr_data = coord_byte(2'd0, x0, x1);
               idx_d   = 2'd0;
               state_d = ST_CASET_PAR;
            end
         end
         ST_CASET_PAR: begin
            if (wr_ready) begin
               wr_load = 1'b1;
               if (idx_q == 2'd3) begin
                  wr_data = OP_PASET;
                  wr_dcx  = 1'b0;
                  state_d = ST_PASET_CMD;
               end else begin
                  wr_data = coord_byte(idx_q + 2'd1, x0, x1);
                  idx_d   = idx_q + 2'd1;
               end
            end
         end
         ST_PASET_CMD: begin
            if (wr_ready) begin
               wr_load = 1'b1;
               wr_data = coord_byte(2'd0, y0, y1);
               idx_d   = 2'd0;
               state_d = ST_PASET_PAR;
            end
         end
         ST_PASET_PAR: begin
            if (wr_ready) begin
               wr_load = 1'b1;
               if (idx_q == 2'd3) begin
                  wr_data = OP_RAMWR;
                  wr_dcx  = 1'b0;
                  state_d = ST_RAMWR_CMD;
               end else begin
                  wr_data = coord_byte(idx_q + 2'd1, y0, y1);
                  idx_d   = idx_q + 2'd1;
               end
            end
         end
         ST_RAMWR_CMD: begin
            if (wr_ready) begin
               wr_load = 1'b1;
               wr_data = color[15:8];
               pix_d   = '0;
               lo_d    = 1'b0;
               state_d = ST_PIXELS;
            end
         end
         ST_PIXELS: begin
            // lo_q marks which half of the current pixel is on the bus.
            if (wr_ready) begin
               if (!lo_q) begin
                  wr_load = 1'b1;
                  wr_data = color[7:0];
                  lo_d    = 1'b1;
               end else if (pix_q == PIX_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  wr_load = 1'b1;
                  wr_data = color[15:8];
                  pix_d   = pix_q + 1'b1;
                  lo_d    = 1'b0;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller state plus registered status and chip-select outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         obj_q   <= '0;
         idx_q   <= '0;
         pix_q   <= '0;
         lo_q    <= 1'b0;
         csx_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         obj_q   <= obj_d;
         idx_q   <= idx_d;
         pix_q   <= pix_d;
         lo_q    <= lo_d;
         csx_q   <= (state_d == ST_IDLE) || (state_d == ST_DONE);
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
      end
   end

   tft_byte_writer u_writer (
      .clk     (clk),
      .nrst    (nrst),
      .load_i  (wr_load),
      .data_i  (wr_data),
      .dcx_i   (wr_dcx),
      .ready_o (wr_ready),
      .wrx_o   (tft_wrx),
      .dcx_o   (tft_dcx),
      .data_o  (tft_data)
   );

   assign tft_csx  = csx_q;
   assign busy     = busy_q;
   assign cmd_done = done_q;

endmodule

// File: tb/tb_cell_painter.sv
// Directed bench for cell_painter: a negedge bus monitor collects every byte
// latched on rising wrx, and each test task compares against hand-derived values.
module tb_cell_painter;

   logic       clk = 1'b0;
   logic       nrst = 1'b1;
   logic       en_update = 1'b0;
   logic [3:0] x = 4'd0, y = 4'd0;
   logic [2:0] obj_code = 3'd0;
   logic       cmd_done, busy, tft_csx, tft_dcx, tft_wrx;
   logic [7:0] tft_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cell_painter dut (
      .clk       (clk),
      .nrst      (nrst),
      .en_update (en_update),
      .x         (x),
      .y         (y),
      .obj_code  (obj_code),
      .cmd_done  (cmd_done),
      .busy      (busy),
      .tft_csx   (tft_csx),
      .tft_dcx   (tft_dcx),
      .tft_wrx   (tft_wrx),
      .tft_data  (tft_data)
   );

   // Bus monitor
   logic [7:0] cap_data[$];
   logic       cap_dcx[$];
   int         done_cnt = 0;
   int         phase_err = 0;
   logic       prev_wrx = 1'b1;
   logic [7:0] a_data = 8'h00;
   logic       a_dcx = 1'b1;

   always @(negedge clk) begin
      if (tft_wrx === 1'b0) begin
         if (tft_csx !== 1'b0) phase_err++;
         a_data = tft_data;
         a_dcx  = tft_dcx;
      end else if (prev_wrx === 1'b0) begin
         if (tft_data !== a_data || tft_dcx !== a_dcx || tft_csx !== 1'b0) phase_err++;
         cap_data.push_back(tft_data);
         cap_dcx.push_back(tft_dcx);
      end
      prev_wrx = tft_wrx;
      if (cmd_done === 1'b1) done_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Counts captured bytes that differ from the expected 811-byte stream; -1 if length is wrong.
   function automatic int bad_bytes(input logic [7:0] hdr [11], input logic [15:0] color);
      int n = 0;
      logic [7:0] eb;
      logic       ed;
      if (cap_data.size() != 811) return -1;
      for (int i = 0; i < 811; i++) begin
         if (i < 11) begin
            eb = hdr[i];
            ed = (i == 0 || i == 5 || i == 10) ? 1'b0 : 1'b1;
         end else begin
            eb = (((i - 11) % 2) == 0) ? color[15:8] : color[7:0];
            ed = 1'b1;
         end
         if (cap_data[i] !== eb || cap_dcx[i] !== ed) n++;
      end
      return n;
   endfunction

   // Issues one request and waits (bounded) for cmd_done; optionally pulses en_update mid-run.
   task automatic run_txn(input logic [3:0] xx, input logic [3:0] yy, input logic [2:0] oo,
                          input int pulse_at, output int lat, output int csx_low,
                          output logic busy1);
      cap_data.delete();
      cap_dcx.delete();
      done_cnt  = 0;
      phase_err = 0;
      x = xx; y = yy; obj_code = oo; en_update = 1'b1;
      @(posedge clk); #1;
      en_update = 1'b0;
      busy1   = busy;
      lat     = 1;
      csx_low = 0;
      while (cmd_done !== 1'b1 && lat < 4000) begin
         if (tft_csx === 1'b0) csx_low++;
         en_update = (lat == pulse_at);
         if (en_update) begin
            x = 4'd9; y = 4'd9; obj_code = 3'd4;
         end
         @(posedge clk); #1;
         lat++;
      end
      en_update = 1'b0;
      if (cmd_done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tft_csx !== 1'b1) begin errors++; $display("FAIL reset_csx got %b want 1", tft_csx); end
      checks++; if (tft_wrx !== 1'b1) begin errors++; $display("FAIL reset_wrx got %b want 1", tft_wrx); end
      checks++; if (tft_dcx !== 1'b1) begin errors++; $display("FAIL reset_dcx got %b want 1", tft_dcx); end
      checks++; if (tft_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", tft_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (cmd_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", cmd_done); end
      nrst = 1'b1;
      @(posedge clk); #1;
   endtask

   // Common post-transaction checks for a full 811-byte cell.
   task automatic test_paint(input string nm, input logic [3:0] xx, input logic [3:0] yy,
                             input logic [2:0] oo, input logic [7:0] hdr [11],
                             input logic [15:0] color, input int pulse_at);
      int   lat, csx_low, nbad;
      logic busy1;
      run_txn(xx, yy, oo, pulse_at, lat, csx_low, busy1);
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL %s busy_cycle1 got %b want 1", nm, busy1); end
      checks++; if (lat !== 1623) begin errors++; $display("FAIL %s done_latency got %0d want 1623", nm, lat); end
      checks++; if (csx_low !== 1622) begin errors++; $display("FAIL %s csx_low_cycles got %0d want 1622", nm, csx_low); end
      checks++; if (tft_csx !== 1'b1) begin errors++; $display("FAIL %s csx_in_done got %b want 1", nm, tft_csx); end
      @(posedge clk); #1;
      checks++; if (cmd_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after_done done=%b busy=%b want 0 0", nm, cmd_done, busy); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", nm, done_cnt); end
      checks++; if (cap_data.size() !== 811) begin errors++; $display("FAIL %s byte_count got %0d want 811", nm, cap_data.size()); end
      nbad = bad_bytes(hdr, color);
      checks++; if (nbad !== 0) begin errors++; $display("FAIL %s byte_stream bad_bytes %0d want 0", nm, nbad); end
      checks++; if (phase_err !== 0) begin errors++; $display("FAIL %s phase_errors got %0d want 0", nm, phase_err); end
   endtask

   task automatic test_paint_head();
      test_paint("head_4_4", 4'd4, 4'd4, 3'b001,
                 '{8'h2A, 8'h00, 8'h50, 8'h00, 8'h63, 8'h2B, 8'h00, 8'h50, 8'h00, 8'h63, 8'h2C},
                 16'hFFE0, 0);
   endtask

   task automatic test_paint_border();
      test_paint("border_15_11", 4'd15, 4'd11, 3'b100,
                 '{8'h2A, 8'h01, 8'h2C, 8'h01, 8'h3F, 8'h2B, 8'h00, 8'hDC, 8'h00, 8'hEF, 8'h2C},
                 16'hFFFF, 0);
   endtask

   task automatic test_reject();
      int   lat, csx_low;
      logic busy1;
      run_txn(4'd3, 4'd12, 3'b001, 0, lat, csx_low, busy1);
      checks++; if (lat !== 1) begin errors++; $display("FAIL reject done_latency got %0d want 1", lat); end
      checks++; if (csx_low !== 0 || tft_csx !== 1'b1) begin errors++; $display("FAIL reject csx_low_cycles got %0d want 0", csx_low); end
      @(posedge clk); #1;
      checks++; if (cap_data.size() !== 0 || phase_err !== 0) begin errors++; $display("FAIL reject bus_bytes got %0d want 0", cap_data.size()); end
      checks++; if (done_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL reject done_pulses got %0d busy %b want 1 0", done_cnt, busy); end
   endtask

   task automatic test_back_to_back();
      // en_update pulsed at cycle 100 of the first cell must be ignored.
      test_paint("busy_ignore_0_0", 4'd0, 4'd0, 3'b010,
                 '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h13, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h13, 8'h2C},
                 16'h07E0, 100);
      // test_paint returns in the cycle after cmd_done: request there must be accepted.
      test_paint("back_to_back_1_2", 4'd1, 4'd2, 3'b011,
                 '{8'h2A, 8'h00, 8'h14, 8'h00, 8'h27, 8'h2B, 8'h00, 8'h28, 8'h00, 8'h3B, 8'h2C},
                 16'hF800, 0);
   endtask

   task automatic test_reset_mid();
      done_cnt = 0;
      x = 4'd7; y = 4'd3; obj_code = 3'b000; en_update = 1'b1;
      @(posedge clk); #1;
      en_update = 1'b0;
      repeat (600) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1 || tft_csx !== 1'b0) begin errors++; $display("FAIL rst_mid pre_busy got %b csx %b want 1 0", busy, tft_csx); end
      nrst = 1'b0;
      #1;
      checks++; if ({tft_csx, tft_wrx, tft_dcx, busy, cmd_done} !== 5'b11100 || tft_data !== 8'h00)
         begin errors++; $display("FAIL rst_mid idle_levels got csx%b wrx%b dcx%b busy%b done%b data%h", tft_csx, tft_wrx, tft_dcx, busy, cmd_done, tft_data); end
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid done_pulses got %0d want 0", done_cnt); end
      test_paint("after_reset_2_5", 4'd2, 4'd5, 3'b101,
                 '{8'h2A, 8'h00, 8'h28, 8'h00, 8'h3B, 8'h2B, 8'h00, 8'h64, 8'h00, 8'h77, 8'h2C},
                 16'hF81F, 0);
   endtask

   initial begin
      #2;
      test_reset();
      test_paint_head();
      test_paint_border();
      test_reject();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cell_painter.md
CELL_PAINTER -- requirements
Module: cell_painter

Interface
REQ-001 SHALL have parameter CELL_PX, default 20, meaning pixels per grid-cell edge.
REQ-002 SHALL have parameter GRID_W, default 16, meaning cells per row; GRID_H, default 12, meaning cells per column.
REQ-003 SHALL have port clk  input  1  system clock, single clock domain; all logic on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_update  input  1  request to paint one cell, sampled only in IDLE.
REQ-006 SHALL have ports x  input  4  cell column, and y  input  4  cell row.
REQ-007 SHALL have port obj_code  input  3  cell content: 000 empty, 001 head, 010 body, 011 apple, 100 border.
REQ-008 SHALL have port cmd_done  output  1  one-cycle pulse when the cell transaction ends.
REQ-009 SHALL have port busy  output  1  transaction in progress.
REQ-010 SHALL have ports tft_csx, tft_dcx, tft_wrx  output  1 each  8080-style chip select, data/command select (0 = command), write strobe.
REQ-011 SHALL have port tft_data  output  8  parallel bus byte.

Function
REQ-012 SHALL accept a request when en_update=1 in IDLE, capturing x, y, obj_code at that edge; en_update while busy SHALL be ignored.
REQ-013 SHALL reject a request with x>=GRID_W or y>=GRID_H: no bus activity, cmd_done pulsed the cycle after acceptance.
REQ-014 SHALL use states IDLE, CASET_CMD, CASET_PAR, PASET_CMD, PASET_PAR, RAMWR_CMD, PIXELS, DONE, in that order.
REQ-015 SHALL send every byte in two cycles: phase A tft_wrx=0 with tft_data/tft_dcx valid; phase B tft_wrx=1, same data (latched on rising wrx).
REQ-016 SHALL drive the sequence: 0x2A, x0[15:8], x0[7:0], x1[15:8], x1[7:0], 0x2B, y0 hi, y0 lo, y1 hi, y1 lo, 0x2C, then CELL_PX*CELL_PX pixels as hi byte then lo byte.
REQ-017 SHALL compute x0=x*CELL_PX, x1=x0+CELL_PX-1, y0=y*CELL_PX, y1=y0+CELL_PX-1 as 16-bit values, zero-extended.
REQ-018 SHALL drive tft_dcx=0 for the three opcode bytes and 1 for all parameter and pixel bytes.
REQ-019 SHALL map obj_code to RGB565: 000 0x0000, 001 0xFFE0, 010 0x07E0, 011 0xF800, 100 0xFFFF, 101-111 0xF81F.
REQ-020 SHALL hold tft_csx=0 from the first phase A through the last phase B, and 1 otherwise.
REQ-021 SHALL start phase A of 0x2A in the cycle after acceptance; default transaction is 811 bytes = 1622 cycles with csx low.
REQ-022 SHALL, in the cycle after the final phase B, raise tft_csx and pulse cmd_done for exactly one cycle (DONE), then return to IDLE.
REQ-023 SHALL assert busy from the cycle after acceptance through the cmd_done cycle inclusive; a new en_update is accepted the cycle after cmd_done.
REQ-024 SHALL count pixels with a counter sized for CELL_PX*CELL_PX; terminal count exits PIXELS with no extra or missing pixel.
REQ-025 SHALL register all outputs (no combinational path from inputs to outputs).

Reset
REQ-026 SHALL on nrst=0 force IDLE, tft_csx=1, tft_dcx=1, tft_wrx=1, tft_data=0x00, cmd_done=0, busy=0.
REQ-027 SHALL on reset mid-transaction abort immediately, without emitting cmd_done; the next request restarts from 0x2A.

Structure
REQ-028 SHALL place obj_code enum, RGB565 color constants, opcodes 0x2A/0x2B/0x2C and GRID_W/GRID_H/CELL_PX defaults in shared package tft_pkg.
REQ-029 SHALL instantiate one sub-module tft_byte_writer implementing the two-phase byte strobe with load/ready handshake.

Verification
REQ-030 Reset: hold nrst=0 -> csx=1, wrx=1, dcx=1, data=0x00, busy=0, cmd_done=0.
REQ-031 Paint x=4,y=4,obj=001 -> bytes 2A,00,50,00,63,2B,00,50,00,63,2C, then 400x(FF,E0); cmd_done pulses once 1623 cycles after acceptance.
REQ-032 Paint x=15,y=11,obj=100 -> params 01,2C,01,3F and 00,DC,00,EF; 400x(FF,FF).
REQ-033 Request y=12 -> no wrx edge, csx stays 1, cmd_done pulses next cycle.
REQ-034 Pulse en_update mid-transaction -> ignored, exactly 811 bytes, one cmd_done; request the cycle after cmd_done is accepted.
REQ-035 nrst low during PIXELS -> bus returns to idle levels, no cmd_done; following request yields a complete 811-byte transaction.
